serial_collector: RTL and testbench

SERIAL_COLLECTOR -- requirements
Module: serial_collector

---
 rtl/collector_pkg.sv | 16 +
 rtl/collect_reg.sv | 26 ++
 rtl/serial_collector.sv | 103 ++++++++++
 tb/tb_serial_collector.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/collector_pkg.sv
// Shared definitions for the serial collector.
//   state_t   : collector FSM states (IDLE, SHIFT, DONE)
//   WIDTH_DEF : default bits per collected word
//   NUM_LANES : number of serial lanes (A, B)
package collector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int NUM_LANES = 2;

endpackage

// File: rtl/collect_reg.sv
// Single-lane right-shift deserializer.
// Serial data arrives LSB first and enters at the MSB, so after WIDTH shifts
// the first bit received sits in q[0].
//   clk      : rising-edge clock
//   clr      : synchronous clear (wins over shift_en)
//   shift_en : shift din in at q[WIDTH-1]
//   din      : serial input bit
//   q        : collected word
module collect_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (shift_en)
            q <= {din, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/serial_collector.sv
// Unloads one WIDTH-bit word from each of two external serial source shift
// registers (lanes A and B) and presents both words together with Valid/Ack.
// With Rotate high, the bits read are fed back to the source so its contents
// survive the unload.
//   Clk, Reset      : clock, synchronous active-high reset
//   Start           : begin an unload (honoured in IDLE only)
//   Rotate          : feed collected bits back to the source
//   Ack             : consumer accepts the words (honoured in DONE only)
//   A_Bit, B_Bit    : serial lane data, LSB first
//   Shift_En        : shift request to the source registers
//   A_Fb, B_Fb      : feedback bits to the source shift inputs
//   A_Word, B_Word  : reassembled words
//   Valid, Busy     : words ready / shifting in progress
module serial_collector
    import collector_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Rotate,
    input  logic             Ack,
    input  logic             A_Bit,
    input  logic             B_Bit,
    output logic             Shift_En,
    output logic             A_Fb,
    output logic             B_Fb,
    output logic [WIDTH-1:0] A_Word,
    output logic [WIDTH-1:0] B_Word,
    output logic             Valid,
    output logic             Busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             shift;

    assign load  = (state == IDLE) && Start;
    assign shift = (state == SHIFT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= '0;
            else if (shift && cnt != FULL)
                cnt <= cnt + 1'b1;
        end
    end

    // The edge that shifts in the last bit also leaves SHIFT, so exactly
    // WIDTH shift edges occur.
    always_comb begin
        state_nxt = state;
        Shift_En  = 1'b0;
        Busy      = 1'b0;
        Valid     = 1'b0;
        case (state)
            IDLE:  if (Start) state_nxt = SHIFT;
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                Valid = 1'b1;
                if (Ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign A_Fb = Rotate & A_Bit;
    assign B_Fb = Rotate & B_Bit;

    logic [NUM_LANES-1:0]            lane_bit;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_word;

    assign lane_bit = {B_Bit, A_Bit};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        collect_reg #(.WIDTH(WIDTH)) u_lane (
            .clk      (Clk),
            .clr      (Reset | load),
            .shift_en (shift),
            .din      (lane_bit[g]),
            .q        (lane_word[g])
        );
    end

    assign A_Word = lane_word[0];
    assign B_Word = lane_word[1];

endmodule

// File: tb/tb_serial_collector.sv
module tb_serial_collector;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset, Start, Rotate, Ack;
    logic         A_Bit, B_Bit;
    logic         Shift_En, A_Fb, B_Fb, Valid, Busy;
    logic [W-1:0] A_Word, B_Word;

    // source shift register model (external to the DUT)
    logic [W-1:0] src_a, src_b, load_a, load_b;
    logic         load_en;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 Clk = ~Clk;

    serial_collector #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Rotate(Rotate), .Ack(Ack),
        .A_Bit(A_Bit), .B_Bit(B_Bit), .Shift_En(Shift_En), .A_Fb(A_Fb),
        .B_Fb(B_Fb), .A_Word(A_Word), .B_Word(B_Word), .Valid(Valid), .Busy(Busy)
    );

    assign A_Bit = src_a[0];
    assign B_Bit = src_b[0];

    always @(posedge Clk) begin
        if (load_en) begin
            src_a <= load_a;
            src_b <= load_b;
        end else if (Shift_En) begin
            src_a <= {A_Fb, src_a[W-1:1]};
            src_b <= {B_Fb, src_b[W-1:1]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         rot0, rot1;
        int           sw;          // shift index at which Rotate switches rot0 -> rot1
        logic [W-1:0] exp_aw, exp_bw, exp_sa, exp_sb;
    } vec_t;

    vec_t vecs[6];

    task automatic load_src(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge Clk);
        load_a = a; load_b = b; load_en = 1'b1;
        @(negedge Clk);
        load_en = 1'b0;
    endtask

    // Pulses Start, then runs until Valid; re-pulses Start at shift index
    // restart_at (or never if negative). Returns shift count, edges to Valid
    // and feedback error count.
    task automatic run_shift(input logic r0, input logic r1, input int sw,
                             input int restart_at,
                             output int shifts, output int cycles, output int fb_err);
        shifts = 0; cycles = 0; fb_err = 0;
        Rotate = r0;
        Start  = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        while (!Valid && cycles < 40) begin
            Rotate = (cycles >= sw) ? r1 : r0;
            Start  = (cycles == restart_at);
            #1;
            if (Shift_En) shifts++;
            if (A_Fb !== (Rotate & src_a[0]) || B_Fb !== (Rotate & src_b[0])) fb_err++;
            @(negedge Clk);
            cycles++;
        end
        Start = 1'b0;
    endtask

    int shifts, cycles, fb_err, hold_err;

    initial begin
        Reset = 1'b1; Start = 1'b0; Rotate = 1'b0; Ack = 1'b0;
        load_en = 1'b0; load_a = '0; load_b = '0;

        //            a      b     r0    r1  sw  exp_aw exp_bw exp_sa exp_sb
        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8, 8'hA5, 8'h3C, 8'h00, 8'h00};
        vecs[1] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 8, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 1'b0, 8, 8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8, 8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 4, 8'hA5, 8'h3C, 8'hA0, 8'h30};
        vecs[5] = '{8'h81, 8'h7E, 1'b1, 1'b0, 4, 8'h81, 8'h7E, 8'h01, 8'h0E};

        // reset state
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rst_shift_en", Shift_En, 1'b0);
        check("rst_busy",     Busy,     1'b0);
        check("rst_valid",    Valid,    1'b0);
        check("rst_a_word",   A_Word,   8'h00);
        check("rst_b_word",   B_Word,   8'h00);

        // Ack in IDLE has no effect
        @(negedge Clk); Ack = 1'b1;
        @(negedge Clk); Ack = 1'b0;
        check("idle_ack_busy",  Busy,  1'b0);
        check("idle_ack_valid", Valid, 1'b0);

        // table-driven transfers
        for (int i = 0; i < 6; i++) begin
            load_src(vecs[i].a, vecs[i].b);
            run_shift(vecs[i].rot0, vecs[i].rot1, vecs[i].sw, -1, shifts, cycles, fb_err);
            check($sformatf("v%0d_valid", i),   Valid,  1'b1);
            check($sformatf("v%0d_shifts", i),  shifts, 8);
            check($sformatf("v%0d_latency", i), cycles + 1, 9);
            check($sformatf("v%0d_fb", i),      fb_err, 0);
            check($sformatf("v%0d_a_word", i),  A_Word, vecs[i].exp_aw);
            check($sformatf("v%0d_b_word", i),  B_Word, vecs[i].exp_bw);
            check($sformatf("v%0d_src_a", i),   src_a,  vecs[i].exp_sa);
            check($sformatf("v%0d_src_b", i),   src_b,  vecs[i].exp_sb);
            Ack = 1'b1;
            @(negedge Clk);
            Ack = 1'b0;
            check($sformatf("v%0d_ack_valid", i), Valid, 1'b0);
            check($sformatf("v%0d_idle_hold", i), A_Word, vecs[i].exp_aw);
        end

        // Start re-pulsed at shift 3 and in DONE: no restart
        load_src(8'h5A, 8'hC3);
        run_shift(1'b0, 1'b0, 8, 3, shifts, cycles, fb_err);
        check("restart_shifts", shifts, 8);
        check("restart_a_word", A_Word, 8'h5A);
        check("restart_b_word", B_Word, 8'hC3);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("done_start_valid", Valid,    1'b1);
        check("done_start_shift", Shift_En, 1'b0);
        check("done_start_a",     A_Word,   8'h5A);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        check("restart_idle", Valid | Busy, 1'b0);

        // Reset at shift cycle 4
        load_src(8'hA5, 8'h3C);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("pre_rst_busy", Busy, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("midrst_shift_en", Shift_En, 1'b0);
        check("midrst_valid",    Valid,    1'b0);
        check("midrst_busy",     Busy,     1'b0);
        check("midrst_a_word",   A_Word,   8'h00);
        check("midrst_b_word",   B_Word,   8'h00);

        // Ack withheld 5 cycles, then Ack+Start together
        load_src(8'h96, 8'h69);
        run_shift(1'b1, 1'b1, 8, -1, shifts, cycles, fb_err);
        hold_err = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (Valid !== 1'b1 || A_Word !== 8'h96 || B_Word !== 8'h69) hold_err++;
        end
        check("hold_errs", hold_err, 0);
        Ack = 1'b1; Start = 1'b1;
        @(negedge Clk);
        Ack = 1'b0; Start = 1'b0;
        check("ackstart_valid", Valid, 1'b0);
        check("ackstart_busy",  Busy,  1'b0);
        @(negedge Clk);
        check("ackstart_dropped", Busy, 1'b0);
        check("ackstart_a_kept",  A_Word, 8'h96);

        // a later Start begins a fresh transfer
        load_src(8'h12, 8'hED);
        run_shift(1'b0, 1'b0, 8, -1, shifts, cycles, fb_err);
        check("new_shifts", shifts, 8);
        check("new_a_word", A_Word, 8'h12);
        check("new_b_word", B_Word, 8'hED);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
